asic_padcfg_seq: RTL
====================

ASIC_PADCFG_SEQ -- requirements
Module: asic_padcfg_seq

Interface
REQ-001 Parameter GPIO, default 9, pads per side.
REQ-002 Parameter CFGW, default 8, config bits per pad.
REQ-003 Parameter STAGGER, default 16, cycles between side enables; legal range >= 1.
REQ-004 Side index SHALL be fixed: 0=WE, 1=NO, 2=EA, 3=SO; pad address a = side*GPIO + pad.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 nreset  input  1  asynchronous active-low reset.
REQ-007 restart  input  1  re-run power-up sequence.
REQ-008 wr_valid  input  1  write request.
REQ-009 wr_ready  output  1  write accept.
REQ-010 wr_addr  input  clog2(4*GPIO)  pad address.
REQ-011 wr_data  input  CFGW+2  {oen, ie, cfg}.
REQ-012 pad_cfg  output  4*GPIO*CFGW  per-pad cfg, pad a at [a*CFGW +: CFGW].
REQ-013 pad_ie  output  4*GPIO  input enable, bit a.
REQ-014 pad_oen  output  4*GPIO  output enable (active low), bit a.
REQ-015 seq_done  output  1  all four sides enabled.
REQ-016 err  output  1  sticky bad-address flag.

Function
REQ-017 Per-pad shadow register {oen, ie, cfg} SHALL hold programmed values; reset value {1, 1, 0}.
REQ-018 Write accepted on a rising edge with wr_valid & wr_ready & wr_addr < 4*GPIO; shadow updates at that edge.
REQ-019 wr_addr >= 4*GPIO with wr_valid & wr_ready: write dropped, err set at that edge.
REQ-020 wr_ready SHALL be registered, 0 in reset, 1 from the first rising edge after nreset release.
REQ-021 Per-side enable bit side_en[3:0]; enabled side outputs = shadow values, combinationally.
REQ-022 Disabled side outputs SHALL be safe state: oen=1, ie=0, cfg=0.
REQ-023 Shadow write to an enabled side visible on outputs in the cycle after the accepting edge.
REQ-024 FSM states: SEQ (side index k=0..3, cycle counter) and RUN.
REQ-025 SEQ: counter counts STAGGER edges; on the STAGGER-th edge side_en[k] sets, counter clears, k increments.
REQ-026 Side k enable rises at edge (k+1)*STAGGER after reset release/restart; SEQ->RUN and seq_done=1 on the same edge as side_en[3].
REQ-027 RUN: hold; side_en=4'hF, seq_done=1.
REQ-028 restart=1 in any state: next edge side_en=0, seq_done=0, err=0, k=0, counter=0, state SEQ.
REQ-029 restart held high: FSM remains at k=0, counter=0; sequence begins at first edge with restart low.
REQ-030 restart and accepted write on same edge: write lands in shadow; restart applied; shadow never cleared by restart.
REQ-031 Counter width clog2(STAGGER+1); no wrap beyond STAGGER.
REQ-032 Writes SHALL be accepted in both SEQ and RUN; writes to disabled sides affect outputs only once enabled.

Reset
REQ-033 nreset low: immediately (asynchronously) side_en=0, seq_done=0, err=0, wr_ready=0, state SEQ k=0, counter=0, all shadows {1,1,0}.
REQ-034 Outputs during reset: pad_oen all 1, pad_ie all 0, pad_cfg all 0.
REQ-035 Reset assertion mid-sequence or in RUN SHALL abort and restart fully on release.

Verification (GPIO=9, CFGW=8, STAGGER=4)
REQ-036 Release reset, no writes -> pad_ie=0 through edge 3; pad_ie[8:0]=1FF at edge 4, [17:9] at 8, [26:18] at 12, [35:27] at 16; seq_done=1 at edge 16; pad_oen all 1 throughout.
REQ-037 At edge 2 write addr 10 data {0,0,8'hA5} -> outputs safe until edge 8; from edge 8 pad_cfg[87:80]=A5, pad_oen[10]=0, pad_ie[10]=0.
REQ-038 In RUN, write addr 0 data {0,1,8'h3C} -> next cycle pad_cfg[7:0]=3C, pad_oen[0]=0, pad_ie[0]=1.
REQ-039 Write addr 36 -> no output change, err=1 next cycle; restart pulse -> err=0.
REQ-040 In RUN pulse restart 1 cycle -> next cycle all outputs safe, seq_done=0; side 0 re-enables 4 edges after restart low with prior shadow values.
REQ-041 Assert nreset at edge 6 (side 0 enabled) -> outputs safe without clock edge; after release shadows read back reset value {1,1,0}.

Source files
------------

// File: rtl/asic_padcfg_seq.sv
// Pad configuration shadow registers with a staggered, side-by-side power-up enable sequence.
// Disabled sides drive the safe state (oen=1, ie=0, cfg=0) regardless of programmed shadows.
module asic_padcfg_seq #(
  parameter int unsigned GPIO    = 9,
  parameter int unsigned CFGW    = 8,
  parameter int unsigned STAGGER = 16
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         restart,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(4*GPIO)-1:0]    wr_addr,
  input  logic [CFGW+1:0]              wr_data,
  output logic [4*GPIO*CFGW-1:0]       pad_cfg,
  output logic [4*GPIO-1:0]            pad_ie,
  output logic [4*GPIO-1:0]            pad_oen,
  output logic                         seq_done,
  output logic                         err
);

  localparam int unsigned NPAD = 4 * GPIO;
  localparam int unsigned DW   = CFGW + 2;
  localparam int unsigned CW   = $clog2(STAGGER + 1);

  typedef enum logic {StSeq, StRun} state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_k, w_k_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [3:0]      r_side_en, w_side_en_d;
  logic            r_wr_ready;
  logic            r_err;
  logic [DW-1:0]   r_shadow [NPAD];

  logic            w_wr_fire;
  logic            w_addr_ok;

  assign w_wr_fire = wr_valid & r_wr_ready;
  assign w_addr_ok = (32'(wr_addr) < NPAD);
  assign wr_ready  = r_wr_ready;
  assign err       = r_err;
  assign seq_done  = (r_state == StRun);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= StSeq;
      r_k        <= 2'd0;
      r_cnt      <= '0;
      r_side_en  <= 4'h0;
      r_wr_ready <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_k        <= w_k_d;
      r_cnt      <= w_cnt_d;
      r_side_en  <= w_side_en_d;
      r_wr_ready <= 1'b1;
      // restart wins over a same-edge bad address so the flag always clears
      if (restart) begin
        r_err <= 1'b0;
      end else if (w_wr_fire && !w_addr_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  // Shadows are only cleared by nreset; restart never touches them.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < NPAD; i++) begin
        r_shadow[i] <= {2'b11, {CFGW{1'b0}}};
      end
    end else if (w_wr_fire && w_addr_ok) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_k_d       = r_k;
    w_cnt_d     = r_cnt;
    w_side_en_d = r_side_en;
    if (restart) begin
      w_state_d   = StSeq;
      w_k_d       = 2'd0;
      w_cnt_d     = '0;
      w_side_en_d = 4'h0;
    end else begin
      unique case (r_state)
        StSeq: begin
          if (r_cnt == CW'(STAGGER - 1)) begin
            w_side_en_d[r_k] = 1'b1;
            w_cnt_d          = '0;
            w_k_d            = r_k + 2'd1;
            if (r_k == 2'd3) begin
              w_state_d = StRun;
            end
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
        StRun: begin
          w_side_en_d = 4'hF;
        end
      endcase
    end
  end

  always_comb begin
    pad_cfg = '0;
    pad_ie  = '0;
    pad_oen = '1;
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned p = 0; p < GPIO; p++) begin
        if (r_side_en[s]) begin
          pad_cfg[(s*GPIO+p)*CFGW +: CFGW] = r_shadow[s*GPIO+p][CFGW-1:0];
          pad_ie[s*GPIO+p]                 = r_shadow[s*GPIO+p][CFGW];
          pad_oen[s*GPIO+p]                = r_shadow[s*GPIO+p][CFGW+1];
        end
      end
    end
  end

endmodule
